// File: rtl/bcd_updown_counter_pkg.sv
// rtl/bcd_updown_counter_pkg.sv - shared BCD constants and helpers for the counter slice
//
// Purpose: decade limits and small helper functions used by bcd_digit and
// bcd_updown_counter.
package bcd_updown_counter_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  // Width of the packed BCD count for a given number of decades.
  function automatic int count_width(input int digits);
    return 4 * digits;
  endfunction

  function automatic logic nibble_valid(input logic [3:0] n);
    return n <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - single BCD decade with load, step and direction
//
// Purpose: one 0..9 decade of the cascaded counter.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   load, load_nibble   parallel load; nibbles above 9 are stored as 0
//   step, up            advance one position in direction up (1) / down (0)
//   digit               registered decade value
//   at_max, at_min      digit is 9 / digit is 0
module bcd_digit
  import bcd_updown_counter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_nibble,
  input  logic       step,
  input  logic       up,
  output logic [3:0] digit,
  output logic       at_max,
  output logic       at_min
);

  assign at_max = (digit == BCD_MAX);
  assign at_min = (digit == BCD_MIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      digit <= BCD_MIN;
    end else if (load) begin
      digit <= nibble_valid(load_nibble) ? load_nibble : BCD_MIN;
    end else if (step) begin
      if (up) begin
        digit <= at_max ? BCD_MIN : digit + 4'd1;
      end else begin
        digit <= at_min ? BCD_MAX : digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - parametrised multi-decade BCD up/down counter
//
// Purpose: DIGITS cascaded decades with enable, direction, parallel load and
// wrap/saturate behaviour at terminal count.
// Parameters:
//   DIGITS  number of decades (1..8)
//   WRAP    1 = wrap at terminal count, 0 = saturate
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   en, up       count enable, direction (1 = up)
//   load         parallel load strobe, load_value nibble i -> decade i
//   count        registered BCD count
//   tc           combinational terminal count, usable as a cascade enable
//   load_err     one cycle high after a load holding a nibble above 9
module bcd_updown_counter
  import bcd_updown_counter_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            en,
  input  logic                            up,
  input  logic                            load,
  input  logic [count_width(DIGITS)-1:0]  load_value,
  output logic [count_width(DIGITS)-1:0]  count,
  output logic                            tc,
  output logic                            load_err
);

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] step;
  logic [DIGITS:0]   chain;
  logic              hold_at_tc;
  logic              any_invalid;

  // chain[i] is high when every decade below i sits at its turnover value
  // for the current direction; chain[DIGITS] therefore marks terminal count.
  always_comb begin
    chain[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      chain[i+1] = chain[i] & (up ? at_max[i] : at_min[i]);
    end
  end

  assign tc = en & chain[DIGITS];

  // In saturate mode the whole counter freezes at terminal count; gating
  // every step keeps the decades from rolling over individually.
  assign hold_at_tc = !WRAP && chain[DIGITS];

  always_comb begin
    any_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!nibble_valid(load_value[4*i +: 4])) begin
        any_invalid = 1'b1;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      assign step[g] = en & ~hold_at_tc & chain[g];

      bcd_digit u_digit (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_nibble (load_value[4*g +: 4]),
        .step        (step[g]),
        .up          (up),
        .digit       (count[4*g +: 4]),
        .at_max      (at_max[g]),
        .at_min      (at_min[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      load_err <= 1'b0;
    end else begin
      load_err <= load & any_invalid;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - self-checking bench for bcd_updown_counter
module tb_bcd_updown_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_value;

  logic [7:0] count_w, count_s;
  logic       tc_w, tc_s, err_w, err_s;
  logic [3:0] lo_count, hi_count;
  logic       lo_tc, hi_tc, lo_err, hi_err;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  // Reference model: plain decimal values 0..99
  int mw, ms;
  bit merr;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(2), .WRAP(1'b1)) dut_w (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_value(load_value), .count(count_w), .tc(tc_w), .load_err(err_w));

  bcd_updown_counter #(.DIGITS(2), .WRAP(1'b0)) dut_s (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_value(load_value), .count(count_s), .tc(tc_s), .load_err(err_s));

  bcd_updown_counter #(.DIGITS(1), .WRAP(1'b1)) dut_lo (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_value(load_value[3:0]), .count(lo_count), .tc(lo_tc), .load_err(lo_err));

  bcd_updown_counter #(.DIGITS(1), .WRAP(1'b1)) dut_hi (
    .clk(clk), .reset(reset), .en(lo_tc), .up(up), .load(load),
    .load_value(load_value[7:4]), .count(hi_count), .tc(hi_tc), .load_err(hi_err));

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic int load_dec(input logic [7:0] lv);
    int t, o;
    t = (lv[7:4] > 4'd9) ? 0 : int'(lv[7:4]);
    o = (lv[3:0] > 4'd9) ? 0 : int'(lv[3:0]);
    return t * 10 + o;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mw <= 0; ms <= 0; merr <= 1'b0;
    end else if (load) begin
      mw <= load_dec(load_value);
      ms <= load_dec(load_value);
      merr <= (load_value[7:4] > 4'd9) || (load_value[3:0] > 4'd9);
    end else begin
      merr <= 1'b0;
      if (en) begin
        if (up) begin
          mw <= (mw + 1) % 100;
          ms <= (ms == 99) ? 99 : ms + 1;
        end else begin
          mw <= (mw + 99) % 100;
          ms <= (ms == 0) ? 0 : ms - 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      chk("count_wrap", 32'(count_w), 32'(to_bcd(mw)));
      chk("count_sat", 32'(count_s), 32'(to_bcd(ms)));
      chk("count_cascade", 32'({hi_count, lo_count}), 32'(to_bcd(mw)));
      chk("tc_wrap", 32'(tc_w), 32'(en && (up ? mw == 99 : mw == 0)));
      chk("tc_sat", 32'(tc_s), 32'(en && (up ? ms == 99 : ms == 0)));
      chk("tc_cascade", 32'(hi_tc), 32'(en && (up ? mw == 99 : mw == 0)));
      chk("load_err_wrap", 32'(err_w), 32'(merr));
      chk("load_err_sat", 32'(err_s), 32'(merr));
      chk("load_err_cascade", 32'(lo_err | hi_err), 32'(merr));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; load_value = 8'h00;
    cyc(1);
    chk_on = 1'b1;
    chk("lit_reset_count", 32'(count_w), 32'h00);
    chk("lit_reset_err", 32'(err_w), 32'h0);
    reset = 1'b0;

    // Count up with decade carry and wrap
    cyc(10);
    chk("lit_up_10", 32'(count_w), 32'h10);
    cyc(89);
    chk("lit_up_99", 32'(count_w), 32'h99);
    chk("lit_tc_99", 32'(tc_w), 32'h1);
    cyc(1);
    chk("lit_wrap_00", 32'(count_w), 32'h00);
    chk("lit_sat_99", 32'(count_s), 32'h99);

    // Count down with borrow
    load = 1'b1; load_value = 8'h10; up = 1'b0;
    cyc(1);
    load = 1'b0;
    cyc(1);
    chk("lit_down_09", 32'(count_w), 32'h09);
    cyc(1);
    chk("lit_down_08", 32'(count_w), 32'h08);
    load = 1'b1; load_value = 8'h00;
    cyc(1);
    load = 1'b0;
    cyc(1);
    chk("lit_down_wrap_99", 32'(count_w), 32'h99);
    chk("lit_down_sat_00", 32'(count_s), 32'h00);

    // Saturate at all-9s, then reverse
    load = 1'b1; load_value = 8'h98; up = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(1);
    chk("lit_sat_up_99", 32'(count_s), 32'h99);
    cyc(1);
    chk("lit_sat_hold_99", 32'(count_s), 32'h99);
    chk("lit_sat_tc", 32'(tc_s), 32'h1);
    up = 1'b0;
    cyc(1);
    chk("lit_sat_rev_98", 32'(count_s), 32'h98);

    // Invalid nibble load
    load = 1'b1; load_value = 8'h3C;
    cyc(1);
    chk("lit_bad_load_count", 32'(count_w), 32'h30);
    chk("lit_bad_load_err", 32'(err_w), 32'h1);
    load = 1'b0; en = 1'b0;
    cyc(1);
    chk("lit_err_clears", 32'(err_w), 32'h0);
    chk("lit_hold_30", 32'(count_w), 32'h30);

    // Priority: reset over load over en
    reset = 1'b1; load = 1'b1; en = 1'b1; load_value = 8'hC3;
    cyc(1);
    chk("lit_prio_reset_count", 32'(count_w), 32'h00);
    chk("lit_prio_reset_err", 32'(err_w), 32'h0);
    reset = 1'b0; load_value = 8'h45; up = 1'b1;
    cyc(1);
    chk("lit_prio_load_45", 32'(count_w), 32'h45);
    load = 1'b0;

    // Back-to-back invalid loads keep load_err high
    load = 1'b1; load_value = 8'hF9;
    cyc(2);
    chk("lit_err_sustained", 32'(err_w), 32'h1);
    load = 1'b0;

    // Directed mixed pattern: direction flips, holds, mid-count reset
    for (int i = 0; i < 300; i++) begin
      en = (i % 7) != 3;
      up = ((i / 23) % 2) == 0;
      reset = (i == 150);
      load = (i % 61) == 60;
      load_value = 8'(i * 37);
      cyc(1);
    end
    reset = 1'b0; load = 1'b0; en = 1'b0;
    cyc(2);
    chk_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
